wb_stage: RTL and testbench
===========================

# wb_stage

MEM/WB pipeline register and writeback stage of the lc3b five-stage pipeline, directly downstream of the memory stage. It latches the memory stage's completed instruction and selects the register-file write data. It generates condition codes, drives the register-file write port and exposes a forwarding tap. It also owns the two-phase LDI/STI sequencer, which captures the pointer word from the first data access and feeds the memory stage's indirect inputs for the second access.

## Interface
Parameters:
- none; widths come from `lc3b_types`.

Ports:
- `clk`  in  1  stage clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `stall_in`  in  1  global pipeline hold (icache/dcache stall); freezes the pipeline register.
- `load_wb`  in  1  memory stage completed its instruction this cycle.
- `valid_in`  in  1  memory-stage valid bit.
- `cw_in`  in  lc3b_control_word  control word from the memory stage; uses `opcode`, `load_regfile`, `load_cc`, `regfilemux_sel`.
- `data_in`  in  16  load data, already byte-aligned.
- `result_in`  in  16  ALU/address result.
- `new_pc_in`  in  16  link PC for JSR/TRAP.
- `dr_in`  in  3  destination register.
- `mem_rdata`  in  16  raw dcache read data.
- `dcache_resp`  in  1  dcache access complete.
- `indirect_data`  out  16  captured pointer word for the second access.
- `indirect_reg`  out  16  destination register for the second phase; bits [2:0] are the DR, upper bits are 0.
- `indirect_result`  out  16  store data held for the second STI access.
- `indirect_sel`  out  1  high while the sequencer is in SECOND.
- `wb_load_regfile`  out  1  register-file write enable.
- `wb_dr`  out  3  register-file write address.
- `wb_data`  out  16  register-file write data; also the forwarding value.
- `wb_load_cc`  out  1  CC register write enable.
- `wb_cc`  out  3  {n,z,p} computed from `wb_data`.
- `wb_fwd_en`  out  1  `wb_valid & cw.load_regfile`; tells the hazard unit that `wb_dr`/`wb_data` are live.

## Operation
Pipeline register:
- Registered fields: `cw`, `data`, `result`, `new_pc`, `dr`, and the valid bit `wb_valid`.
- `stall_in`=1: hold all fields.
- Otherwise: load all fields, with `wb_valid <= valid_in & load_wb`.
- When `load_wb`=0, a bubble (`wb_valid`=0) enters the stage.

Writeback mux on `cw.regfilemux_sel`:
- `rf_alu` → `result`
- `rf_mem` → `data`
- `rf_pc` → `new_pc`
- `rf_rsvd` → `result`

Outputs from the register:
- `wb_load_regfile = wb_valid & cw.load_regfile`
- `wb_load_cc = wb_valid & cw.load_cc`
- `wb_cc`: 100 if `wb_data[15]`; 010 if `wb_data==0`; else 001. Combinational from `wb_data`.
- Writes repeated while held by `stall_in` are idempotent and permitted.

Indirect sequencer, states IDLE and SECOND:
- `ind_op = valid_in & (cw_in.opcode==op_ldi | cw_in.opcode==op_sti)`.
- IDLE → SECOND when `ind_op & dcache_resp`. On that edge capture:
  - `indirect_data <= mem_rdata`
  - `indirect_reg <= {13'b0, dr_in}`
  - `indirect_result <= result_in`
- SECOND → IDLE on `dcache_resp`. The instruction then completes through the memory stage (`load_wb`=1) and enters the pipeline register normally.
- Captured registers hold their value in IDLE; they are not cleared.
- `stall_in` does not gate the sequencer; it is driven only by dcache handshakes.

## Timing
- Reset (async, `reset_n`=0): `wb_valid`=0, all registered fields 0, sequencer IDLE, indirect registers 0.
- Reset values of outputs: `wb_load_regfile`=0, `wb_load_cc`=0, `wb_fwd_en`=0, `wb_data`=0, `wb_cc`=010, `indirect_sel`=0.
- Reset asserted mid-indirect returns the sequencer to IDLE immediately.
- Latency: memory-stage values visible on `wb_*` one cycle after the edge where `load_wb`=1 & `stall_in`=0. Register-file write happens on the following edge.
- `indirect_sel` rises the cycle after the first `dcache_resp` and falls the cycle after the second.
- A back-to-back LDI/STI re-enters SECOND on its own first response.
- `stall_in` and `load_wb` simultaneously: `stall_in` wins; the register holds.

## Structure
- Add to `lc3b_types`: enum `lc3b_regfilemux_sel` {`rf_alu`, `rf_mem`, `rf_pc`, `rf_rsvd`}, and the `regfilemux_sel` field of `lc3b_control_word`.
- Add to `lc3b_types`: enum `lc3b_ind_state` {`IND_IDLE`, `IND_SECOND`}.
- One sub-module, `indirect_seq`, holding the FSM and the three capture registers. Mux and CC generation stay inline.

## Test plan
- ADD, `result_in`=0x8001, `load_wb`=1, `regfilemux_sel`=`rf_alu`, `dr_in`=3 → next cycle `wb_data`=0x8001, `wb_dr`=3, `wb_load_regfile`=1, `wb_cc`=100.
- LDR, `data_in`=0x0000, `rf_mem` → `wb_data`=0, `wb_cc`=010, `wb_load_cc`=1.
- JSR, `new_pc_in`=0x3002, `rf_pc`, `dr_in`=7 → `wb_data`=0x3002, `wb_dr`=7.
- LDI:
  - First `dcache_resp` with `mem_rdata`=0x4000 → `indirect_sel`=1, `indirect_data`=0x4000.
  - Second resp → `indirect_sel`=0.
  - Then `load_wb` → `wb_data`=loaded value.
- `stall_in`=1 for 3 cycles with a changing `result_in` → `wb_data` constant; after release, the new value appears one cycle later.
- `reset_n` pulsed low while in SECOND → `indirect_sel`=0 and `wb_valid`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the lc3b pipeline.
// Contents:
//   lc3b_word / lc3b_reg / lc3b_nzp : basic datapath widths
//   lc3b_opcode                     : 4-bit ISA opcodes
//   lc3b_regfilemux_sel             : writeback data source select
//   lc3b_ind_state                  : LDI/STI sequencer states
//   lc3b_control_word               : per-instruction control bundle
//   lc3b_wb_ctrl                    : control fields kept in the MEM/WB register
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;
   typedef logic [2:0]  lc3b_nzp;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {
      rf_alu  = 2'b00,
      rf_mem  = 2'b01,
      rf_pc   = 2'b10,
      rf_rsvd = 2'b11
   } lc3b_regfilemux_sel;

   typedef enum logic {
      IND_IDLE   = 1'b0,
      IND_SECOND = 1'b1
   } lc3b_ind_state;

   typedef struct packed {
      lc3b_opcode         opcode;
      logic               load_regfile;
      logic               load_cc;
      lc3b_regfilemux_sel regfilemux_sel;
   } lc3b_control_word;

   // Writeback only needs these fields; the opcode is consumed by the
   // indirect sequencer straight from the memory-stage control word.
   typedef struct packed {
      logic               load_regfile;
      logic               load_cc;
      lc3b_regfilemux_sel regfilemux_sel;
   } lc3b_wb_ctrl;

   localparam lc3b_nzp CC_N = 3'b100;
   localparam lc3b_nzp CC_Z = 3'b010;
   localparam lc3b_nzp CC_P = 3'b001;

endpackage

// File: rtl/indirect_seq.sv
// indirect_seq: two-phase LDI/STI sequencer.
// Ports:
//   clk, reset_n       : clock, async active-low reset
//   ind_op             : memory stage holds a valid LDI/STI
//   dcache_resp        : dcache access complete
//   mem_rdata          : raw dcache read data (pointer word on first access)
//   dr_in, result_in   : destination register / store data to hold
//   indirect_data      : captured pointer word
//   indirect_reg       : {13'b0, DR} for the second phase
//   indirect_result    : store data for the second STI access
//   indirect_sel       : high while in the second phase
module indirect_seq
   import lc3b_types::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     ind_op,
   input  logic     dcache_resp,
   input  lc3b_word mem_rdata,
   input  lc3b_reg  dr_in,
   input  lc3b_word result_in,
   output lc3b_word indirect_data,
   output lc3b_word indirect_reg,
   output lc3b_word indirect_result,
   output logic     indirect_sel
);

   lc3b_ind_state state_q;
   lc3b_word      data_q;
   lc3b_word      reg_q;
   lc3b_word      result_q;
   logic          sel_q;

   // Driven purely by dcache handshakes; the global stall does not gate it.
   // Capture registers keep their contents after returning to IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IND_IDLE;
         sel_q    <= 1'b0;
         data_q   <= '0;
         reg_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IND_IDLE: begin
               if (ind_op && dcache_resp) begin
                  state_q  <= IND_SECOND;
                  sel_q    <= 1'b1;
                  data_q   <= mem_rdata;
                  reg_q    <= {13'b0, dr_in};
                  result_q <= result_in;
               end
            end
            IND_SECOND: begin
               if (dcache_resp) begin
                  state_q <= IND_IDLE;
                  sel_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IND_IDLE;
               sel_q   <= 1'b0;
            end
         endcase
      end
   end

   assign indirect_data   = data_q;
   assign indirect_reg    = reg_q;
   assign indirect_result = result_q;
   assign indirect_sel    = sel_q;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback stage.
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   stall_in                  : global hold, freezes the pipeline register
//   load_wb, valid_in         : memory stage completed / valid
//   cw_in                     : memory-stage control word
//   data_in/result_in/new_pc_in/dr_in : writeback candidates and destination
//   mem_rdata, dcache_resp    : raw dcache data / handshake for LDI/STI
//   indirect_*                : second-phase values to the memory stage
//   wb_load_regfile, wb_dr, wb_data   : register-file write port (+ forwarding)
//   wb_load_cc, wb_cc         : condition-code write
//   wb_fwd_en                 : wb_dr/wb_data are live for forwarding
module wb_stage
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall_in,
   input  logic             load_wb,
   input  logic             valid_in,
   input  lc3b_control_word cw_in,
   input  lc3b_word         data_in,
   input  lc3b_word         result_in,
   input  lc3b_word         new_pc_in,
   input  lc3b_reg          dr_in,
   input  lc3b_word         mem_rdata,
   input  logic             dcache_resp,
   output lc3b_word         indirect_data,
   output lc3b_word         indirect_reg,
   output lc3b_word         indirect_result,
   output logic             indirect_sel,
   output logic             wb_load_regfile,
   output lc3b_reg          wb_dr,
   output lc3b_word         wb_data,
   output logic             wb_load_cc,
   output lc3b_nzp          wb_cc,
   output logic             wb_fwd_en
);

   lc3b_wb_ctrl cw_q,     cw_d;
   lc3b_word    data_q,   data_d;
   lc3b_word    result_q, result_d;
   lc3b_word    new_pc_q, new_pc_d;
   lc3b_reg     dr_q,     dr_d;
   logic        valid_q,  valid_d;
   logic        ind_op;

   // A missing load_wb still loads the fields but marks the slot as a bubble.
   always_comb begin
      cw_d     = cw_q;
      data_d   = data_q;
      result_d = result_q;
      new_pc_d = new_pc_q;
      dr_d     = dr_q;
      valid_d  = valid_q;
      if (!stall_in) begin
         cw_d     = '{load_regfile:   cw_in.load_regfile,
                      load_cc:        cw_in.load_cc,
                      regfilemux_sel: cw_in.regfilemux_sel};
         data_d   = data_in;
         result_d = result_in;
         new_pc_d = new_pc_in;
         dr_d     = dr_in;
         valid_d  = valid_in & load_wb;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cw_q     <= '0;
         data_q   <= '0;
         result_q <= '0;
         new_pc_q <= '0;
         dr_q     <= '0;
         valid_q  <= 1'b0;
      end else begin
         cw_q     <= cw_d;
         data_q   <= data_d;
         result_q <= result_d;
         new_pc_q <= new_pc_d;
         dr_q     <= dr_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      case (cw_q.regfilemux_sel)
         rf_alu:  wb_data = result_q;
         rf_mem:  wb_data = data_q;
         rf_pc:   wb_data = new_pc_q;
         default: wb_data = result_q;
      endcase
   end

   always_comb begin
      if (wb_data[15])         wb_cc = CC_N;
      else if (wb_data == '0)  wb_cc = CC_Z;
      else                     wb_cc = CC_P;
   end

   assign wb_dr           = dr_q;
   assign wb_load_regfile = valid_q & cw_q.load_regfile;
   assign wb_load_cc      = valid_q & cw_q.load_cc;
   assign wb_fwd_en       = valid_q & cw_q.load_regfile;

   assign ind_op = valid_in & ((cw_in.opcode == op_ldi) | (cw_in.opcode == op_sti));

   indirect_seq u_indirect_seq (
      .clk             (clk),
      .reset_n         (reset_n),
      .ind_op          (ind_op),
      .dcache_resp     (dcache_resp),
      .mem_rdata       (mem_rdata),
      .dr_in           (dr_in),
      .result_in       (result_in),
      .indirect_data   (indirect_data),
      .indirect_reg    (indirect_reg),
      .indirect_result (indirect_result),
      .indirect_sel    (indirect_sel)
   );

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage.
module tb_wb_stage;
   import lc3b_types::*;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             stall_in = 1'b0;
   logic             load_wb = 1'b0;
   logic             valid_in = 1'b0;
   logic             dcache_resp = 1'b0;
   lc3b_control_word cw_in = '0;
   logic [15:0]      data_in = '0, result_in = '0, new_pc_in = '0, mem_rdata = '0;
   logic [2:0]       dr_in = '0;

   logic [15:0] indirect_data, indirect_reg, indirect_result, wb_data;
   logic        indirect_sel, wb_load_regfile, wb_load_cc, wb_fwd_en;
   logic [2:0]  wb_dr, wb_cc;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  dr;
      logic        lrf;
      logic        lcc;
   } exp_t;
   exp_t sb[$];

   wb_stage dut (
      .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .load_wb(load_wb),
      .valid_in(valid_in), .cw_in(cw_in), .data_in(data_in), .result_in(result_in),
      .new_pc_in(new_pc_in), .dr_in(dr_in), .mem_rdata(mem_rdata),
      .dcache_resp(dcache_resp), .indirect_data(indirect_data),
      .indirect_reg(indirect_reg), .indirect_result(indirect_result),
      .indirect_sel(indirect_sel), .wb_load_regfile(wb_load_regfile),
      .wb_dr(wb_dr), .wb_data(wb_data), .wb_load_cc(wb_load_cc),
      .wb_cc(wb_cc), .wb_fwd_en(wb_fwd_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] model_cc(input logic [15:0] v);
      if (v[15])       return 3'b100;
      else if (v == 0) return 3'b010;
      else             return 3'b001;
   endfunction

   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("wb_data", wb_data, e.data);
      chk("wb_dr", wb_dr, e.dr);
      chk("wb_load_regfile", wb_load_regfile, e.lrf);
      chk("wb_load_cc", wb_load_cc, e.lcc);
      chk("wb_fwd_en", wb_fwd_en, e.lrf);
      chk("wb_cc", wb_cc, model_cc(e.data));
   endtask

   // Drive one completing instruction and check it one cycle later.
   task automatic send(input lc3b_opcode op, input lc3b_regfilemux_sel sel,
                       input logic lrf, input logic lcc, input logic [15:0] d,
                       input logic [15:0] r, input logic [15:0] pc, input logic [2:0] dr);
      exp_t e;
      @(negedge clk);
      cw_in       = '{op, lrf, lcc, sel};
      data_in     = d;
      result_in   = r;
      new_pc_in   = pc;
      dr_in       = dr;
      load_wb     = 1'b1;
      valid_in    = 1'b1;
      stall_in    = 1'b0;
      dcache_resp = 1'b0;
      e.data = (sel == rf_mem) ? d : (sel == rf_pc) ? pc : r;
      e.dr   = dr;
      e.lrf  = lrf;
      e.lcc  = lcc;
      sb.push_back(e);
      @(posedge clk); #1;
      load_wb  = 1'b0;
      valid_in = 1'b0;
      compare_head();
   endtask

   task automatic ind_cycle(input lc3b_opcode op, input logic resp, input logic [15:0] rd,
                            input logic [2:0] dr, input logic [15:0] r);
      @(negedge clk);
      cw_in       = '{op, (op == op_ldi), (op == op_ldi), rf_mem};
      valid_in    = 1'b1;
      load_wb     = 1'b0;
      dcache_resp = resp;
      mem_rdata   = rd;
      dr_in       = dr;
      result_in   = r;
      @(posedge clk); #1;
      dcache_resp = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_load_regfile", wb_load_regfile, 1'b0);
      chk("rst_load_cc", wb_load_cc, 1'b0);
      chk("rst_fwd_en", wb_fwd_en, 1'b0);
      chk("rst_wb_data", wb_data, 16'h0000);
      chk("rst_wb_cc", wb_cc, 3'b010);
      chk("rst_indirect_sel", indirect_sel, 1'b0);
      chk("rst_indirect_data", indirect_data, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;

      // basic writeback sources
      send(op_add, rf_alu,  1'b1, 1'b1, 16'h0000, 16'h8001, 16'h0000, 3'd3);
      send(op_ldr, rf_mem,  1'b1, 1'b1, 16'h0000, 16'h1234, 16'h5555, 3'd1);
      send(op_jsr, rf_pc,   1'b1, 1'b0, 16'hAAAA, 16'hBBBB, 16'h3002, 3'd7);
      send(op_add, rf_rsvd, 1'b1, 1'b1, 16'h1111, 16'h0042, 16'h2222, 3'd2);
      send(op_str, rf_alu,  1'b0, 1'b0, 16'h0000, 16'h7FFF, 16'h0000, 3'd6);
      for (int i = 0; i < 4; i++)
         send(op_and, rf_alu, 1'b1, 1'b1, 16'h0000, 16'($urandom_range(0, 65535)),
              16'h0000, 3'(i));

      // bubble: valid but no load_wb, then load_wb without valid
      @(negedge clk);
      cw_in = '{op_add, 1'b1, 1'b1, rf_alu};
      valid_in = 1'b1; load_wb = 1'b0; result_in = 16'h0F0F;
      @(posedge clk); #1;
      chk("bubble_lrf", wb_load_regfile, 1'b0);
      chk("bubble_fwd", wb_fwd_en, 1'b0);
      @(negedge clk);
      valid_in = 1'b0; load_wb = 1'b1;
      @(posedge clk); #1;
      chk("novalid_lcc", wb_load_cc, 1'b0);
      chk("novalid_fwd", wb_fwd_en, 1'b0);
      load_wb = 1'b0;

      // stall holds the register, even with load_wb asserted
      send(op_add, rf_alu, 1'b1, 1'b1, 16'h0000, 16'h1111, 16'h0000, 3'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stall_in = 1'b1; load_wb = 1'b1; valid_in = 1'b1;
         result_in = 16'h2000 + 16'(i); dr_in = 3'd5;
         @(posedge clk); #1;
         chk("stall_wb_data", wb_data, 16'h1111);
         chk("stall_wb_dr", wb_dr, 3'd2);
         chk("stall_lrf", wb_load_regfile, 1'b1);
      end
      send(op_add, rf_alu, 1'b1, 1'b1, 16'h0000, 16'h2222, 16'h0000, 3'd4);

      // LDI: pointer capture, second access, completion
      ind_cycle(op_ldi, 1'b1, 16'h4000, 3'd5, 16'h0BAD);
      chk("ldi_sel_rise", indirect_sel, 1'b1);
      chk("ldi_ind_data", indirect_data, 16'h4000);
      chk("ldi_ind_reg", indirect_reg, 16'h0005);
      chk("ldi_ind_result", indirect_result, 16'h0BAD);
      ind_cycle(op_ldi, 1'b0, 16'hFFFF, 3'd5, 16'h0BAD);
      chk("ldi_sel_wait", indirect_sel, 1'b1);
      ind_cycle(op_ldi, 1'b1, 16'h7777, 3'd5, 16'h0BAD);
      chk("ldi_sel_fall", indirect_sel, 1'b0);
      chk("ldi_ind_hold", indirect_data, 16'h4000);
      send(op_ldi, rf_mem, 1'b1, 1'b1, 16'h7777, 16'h0BAD, 16'h0000, 3'd5);

      // live writeback held by stall while STIs run back to back
      send(op_add, rf_alu, 1'b1, 1'b1, 16'h0000, 16'h0042, 16'h0000, 3'd4);
      stall_in = 1'b1;
      ind_cycle(op_sti, 1'b1, 16'h5000, 3'd1, 16'hA5A5);
      chk("sti_sel_rise", indirect_sel, 1'b1);
      chk("sti_ind_result", indirect_result, 16'hA5A5);
      ind_cycle(op_sti, 1'b1, 16'h0000, 3'd1, 16'hA5A5);
      chk("sti_sel_fall", indirect_sel, 1'b0);
      ind_cycle(op_sti, 1'b1, 16'h6000, 3'd2, 16'h5A5A);
      chk("b2b_sel", indirect_sel, 1'b1);
      chk("b2b_ind_data", indirect_data, 16'h6000);
      chk("b2b_ind_result", indirect_result, 16'h5A5A);
      chk("b2b_ind_reg", indirect_reg, 16'h0002);
      chk("held_fwd_en", wb_fwd_en, 1'b1);
      chk("held_wb_data", wb_data, 16'h0042);

      // asynchronous reset mid-indirect
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_indirect_sel", indirect_sel, 1'b0);
      chk("arst_fwd_en", wb_fwd_en, 1'b0);
      chk("arst_lrf", wb_load_regfile, 1'b0);
      chk("arst_wb_data", wb_data, 16'h0000);
      chk("arst_wb_cc", wb_cc, 3'b010);
      chk("arst_ind_data", indirect_data, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      stall_in = 1'b0;
      valid_in = 1'b0;

      send(op_not, rf_alu, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'h0000, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
